// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the accumulator CPU control unit:
// FSM states, opcode map and the control-word bundle.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RST,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_HALT
  } ctrl_state_e;

  localparam logic [2:0] OP_LDA  = 3'b000;
  localparam logic [2:0] OP_STA  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_JMP  = 3'b100;
  localparam logic [2:0] OP_JZ   = 3'b101;
  localparam logic [2:0] OP_LDI  = 3'b110;
  localparam logic [2:0] OP_MISC = 3'b111;

  localparam logic [3:0] SUB_INC = 4'h0;
  localparam logic [3:0] SUB_CMA = 4'h1;
  localparam logic [3:0] SUB_SHR = 4'h2;
  localparam logic [3:0] SUB_SHL = 4'h3;
  localparam logic [3:0] SUB_CLA = 4'h4;
  localparam logic [3:0] SUB_STC = 4'h5;
  localparam logic [3:0] SUB_CLC = 4'h6;
  localparam logic [3:0] SUB_HLT = 4'hF;

  typedef struct packed {
    logic mem_rd;
    logic mem_wr;
    logic ir_on_adr;
    logic pc_on_adr;
    logic data_on_dbus;
    logic dbus_on_data;
    logic alu_on_dbus;
    logic load_ir;
    logic load_pc;
    logic inc;
    logic clr_pc;
    logic load_ac;
    logic increm;
    logic comp;
    logic sr;
    logic sleft;
    logic zero;
    logic ldimm;
    logic add;
    logic mult;
    logic pass;
    logic stcrry;
    logic clrcrry;
    logic halted;
  } ctrl_word_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational strobe map from FSM state and IR fields
// to the full datapath control word.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  ctrl_state_e state,
  input  logic [2:0]  op_code,
  input  logic [3:0]  sub_op,
  input  logic        zeroflagac,
  input  logic        mem_ready,
  output ctrl_word_t  cw
);

  always_comb begin
    cw = '0;
    cw.pc_on_adr    = 1'b1;
    cw.data_on_dbus = 1'b1;
    unique case (state)
      ST_RST: cw.clr_pc = 1'b1;
      ST_FETCH: begin
        cw.mem_rd  = 1'b1;
        cw.load_ir = mem_ready;
        cw.inc     = mem_ready;
      end
      ST_MEM: begin
        cw.ir_on_adr = 1'b1;
        cw.pc_on_adr = 1'b0;
        if (op_code == OP_STA) begin
          cw.mem_wr       = 1'b1;
          cw.pass         = 1'b1;
          cw.alu_on_dbus  = 1'b1;
          cw.dbus_on_data = 1'b1;
          cw.data_on_dbus = 1'b0;
        end else begin
          cw.mem_rd  = 1'b1;
          cw.load_ac = mem_ready;
        end
      end
      ST_EXEC: begin
        unique case (op_code)
          OP_ADD, OP_MUL: begin
            cw.add          = (op_code == OP_ADD);
            cw.mult         = (op_code == OP_MUL);
            cw.alu_on_dbus  = 1'b1;
            cw.dbus_on_data = 1'b1;
            cw.data_on_dbus = 1'b0;
            cw.load_ac      = 1'b1;
          end
          OP_JMP: cw.load_pc = 1'b1;
          OP_JZ:  cw.load_pc = zeroflagac;
          OP_LDI: cw.ldimm   = 1'b1;
          OP_MISC: begin
            case (sub_op)
              SUB_INC: cw.increm  = 1'b1;
              SUB_CMA: cw.comp    = 1'b1;
              SUB_SHR: cw.sr      = 1'b1;
              SUB_SHL: cw.sleft   = 1'b1;
              SUB_CLA: cw.zero    = 1'b1;
              SUB_STC: cw.stcrry  = 1'b1;
              SUB_CLC: cw.clrcrry = 1'b1;
              default: ;
            endcase
          end
          default: ;
        endcase
      end
      ST_HALT: cw.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle control FSM for the 16-bit accumulator CPU,
// including memory handshake timeout into a sticky bus error.
module cpu_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] op_code,
  input  logic [3:0] sub_op,
  input  logic       zeroflagac,
  input  logic       mem_ready,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       ir_on_adr,
  output logic       pc_on_adr,
  output logic       data_on_dbus,
  output logic       dbus_on_data,
  output logic       alu_on_dbus,
  output logic       load_ir,
  output logic       load_pc,
  output logic       inc,
  output logic       clr_pc,
  output logic       load_ac,
  output logic       increm,
  output logic       comp,
  output logic       sr,
  output logic       sleft,
  output logic       zero,
  output logic       ldimm,
  output logic       add,
  output logic       mult,
  output logic       pass,
  output logic       stcrry,
  output logic       clrcrry,
  output logic       halted,
  output logic       bus_err
);

  ctrl_state_e state, state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic waiting, timeout;
  ctrl_word_t cw;

  assign waiting = ((state == ST_FETCH) || (state == ST_MEM)) && !mem_ready;
  assign timeout = waiting && (wait_cnt == CNT_W'(WAIT_LIMIT - 1));

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_RST:   state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (timeout)        state_nxt = ST_HALT;
        else if (mem_ready) state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        if (op_code == OP_LDA || op_code == OP_STA)
          state_nxt = ST_MEM;
        else
          state_nxt = ST_EXEC;
      end
      ST_MEM: begin
        if (timeout)        state_nxt = ST_HALT;
        else if (mem_ready) state_nxt = ST_FETCH;
      end
      ST_EXEC: begin
        if (op_code == OP_MISC && sub_op == SUB_HLT)
          state_nxt = ST_HALT;
        else
          state_nxt = ST_FETCH;
      end
      ST_HALT:  state_nxt = ST_HALT;
      default:  state_nxt = ST_RST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RST;
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || !waiting)
        wait_cnt <= '0;
      else
        wait_cnt <= wait_cnt + 1'b1;
      if (timeout)
        bus_err <= 1'b1;
    end
  end

  ctrl_decode u_decode (
    .state      (state),
    .op_code    (op_code),
    .sub_op     (sub_op),
    .zeroflagac (zeroflagac),
    .mem_ready  (mem_ready),
    .cw         (cw)
  );

  assign mem_rd       = cw.mem_rd;
  assign mem_wr       = cw.mem_wr;
  assign ir_on_adr    = cw.ir_on_adr;
  assign pc_on_adr    = cw.pc_on_adr;
  assign data_on_dbus = cw.data_on_dbus;
  assign dbus_on_data = cw.dbus_on_data;
  assign alu_on_dbus  = cw.alu_on_dbus;
  assign load_ir      = cw.load_ir;
  assign load_pc      = cw.load_pc;
  assign inc          = cw.inc;
  assign clr_pc       = cw.clr_pc;
  assign load_ac      = cw.load_ac;
  assign increm       = cw.increm;
  assign comp         = cw.comp;
  assign sr           = cw.sr;
  assign sleft        = cw.sleft;
  assign zero         = cw.zero;
  assign ldimm        = cw.ldimm;
  assign add          = cw.add;
  assign mult         = cw.mult;
  assign pass         = cw.pass;
  assign stcrry       = cw.stcrry;
  assign clrcrry      = cw.clrcrry;
  assign halted       = cw.halted;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Scoreboard bench for cpu_control_unit: per-cycle expected
// strobe vectors queued with stimulus, popped at sample time.
module tb_cpu_control_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] op_code = '0;
  logic [3:0] sub_op = '0;
  logic zeroflagac = 1'b0;
  logic mem_ready = 1'b0;

  logic mem_rd, mem_wr, ir_on_adr, pc_on_adr;
  logic data_on_dbus, dbus_on_data, alu_on_dbus;
  logic load_ir, load_pc, inc, clr_pc;
  logic load_ac, increm, comp, sr, sleft, zero, ldimm;
  logic add, mult, pass, stcrry, clrcrry, halted, bus_err;

  always #5 clk = ~clk;

  cpu_control_unit #(.WAIT_LIMIT(15), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_code(op_code), .sub_op(sub_op),
    .zeroflagac(zeroflagac), .mem_ready(mem_ready),
    .mem_rd(mem_rd), .mem_wr(mem_wr),
    .ir_on_adr(ir_on_adr), .pc_on_adr(pc_on_adr),
    .data_on_dbus(data_on_dbus), .dbus_on_data(dbus_on_data),
    .alu_on_dbus(alu_on_dbus),
    .load_ir(load_ir), .load_pc(load_pc), .inc(inc),
    .clr_pc(clr_pc), .load_ac(load_ac),
    .increm(increm), .comp(comp), .sr(sr), .sleft(sleft),
    .zero(zero), .ldimm(ldimm),
    .add(add), .mult(mult), .pass(pass),
    .stcrry(stcrry), .clrcrry(clrcrry),
    .halted(halted), .bus_err(bus_err)
  );

  logic [24:0] obs;
  assign obs = {halted, bus_err, mem_rd, mem_wr, ir_on_adr,
                pc_on_adr, data_on_dbus, dbus_on_data,
                alu_on_dbus, load_ir, load_pc, inc, clr_pc,
                load_ac, increm, comp, sr, sleft, zero, ldimm,
                add, mult, pass, stcrry, clrcrry};

  localparam logic [24:0] M_HALT = 25'h1 << 24;
  localparam logic [24:0] M_BERR = 25'h1 << 23;
  localparam logic [24:0] M_RD   = 25'h1 << 22;
  localparam logic [24:0] M_WR   = 25'h1 << 21;
  localparam logic [24:0] M_IRA  = 25'h1 << 20;
  localparam logic [24:0] M_PCA  = 25'h1 << 19;
  localparam logic [24:0] M_DOD  = 25'h1 << 18;
  localparam logic [24:0] M_DBD  = 25'h1 << 17;
  localparam logic [24:0] M_ALU  = 25'h1 << 16;
  localparam logic [24:0] M_LIR  = 25'h1 << 15;
  localparam logic [24:0] M_LPC  = 25'h1 << 14;
  localparam logic [24:0] M_INC  = 25'h1 << 13;
  localparam logic [24:0] M_CLR  = 25'h1 << 12;
  localparam logic [24:0] M_LAC  = 25'h1 << 11;
  localparam logic [24:0] M_IAC  = 25'h1 << 10;
  localparam logic [24:0] M_CMP  = 25'h1 << 9;
  localparam logic [24:0] M_SR   = 25'h1 << 8;
  localparam logic [24:0] M_SL   = 25'h1 << 7;
  localparam logic [24:0] M_ZER  = 25'h1 << 6;
  localparam logic [24:0] M_LDI  = 25'h1 << 5;
  localparam logic [24:0] M_ADD  = 25'h1 << 4;
  localparam logic [24:0] M_MUL  = 25'h1 << 3;
  localparam logic [24:0] M_PAS  = 25'h1 << 2;
  localparam logic [24:0] M_STC  = 25'h1 << 1;
  localparam logic [24:0] M_CLC  = 25'h1;

  localparam logic [24:0] P   = M_PCA | M_DOD;
  localparam logic [24:0] FET = P | M_RD | M_LIR | M_INC;

  typedef struct packed {
    logic        rst;
    logic [2:0]  op;
    logic [3:0]  sub;
    logic        z;
    logic        rdy;
    logic [24:0] exp;
  } row_t;

  int n_run = 0;
  int n_fail = 0;
  logic [24:0] sb[$];

  function automatic row_t mk(logic r, logic [2:0] o, logic [3:0] s,
                              logic zf, logic rd, logic [24:0] e);
    row_t x;
    x.rst = r; x.op = o; x.sub = s; x.z = zf; x.rdy = rd; x.exp = e;
    return x;
  endfunction

  task automatic apply(input row_t r);
    rst_n = r.rst;
    op_code = r.op;
    sub_op = r.sub;
    zeroflagac = r.z;
    mem_ready = r.rdy;
    sb.push_back(r.exp);
  endtask

  always @(negedge clk) begin
    #2;
    n_run++;
    if (!$onehot({ir_on_adr, pc_on_adr}) ||
        !$onehot({dbus_on_data, data_on_dbus}) ||
        (alu_on_dbus && !dbus_on_data)) begin
      n_fail++;
      $display("FAIL bus_invariant t=%0t got ir/pc=%b%b dbd/dod/alu=%b%b%b required onehot",
               $time, ir_on_adr, pc_on_adr, dbus_on_data, data_on_dbus, alu_on_dbus);
    end
  end

  task automatic test_reset;
    row_t q[$];
    logic [24:0] e;
    q.push_back(mk(0, 3'd1, 0, 0, 0, P | M_CLR));
    q.push_back(mk(1, 3'd1, 0, 0, 0, P | M_CLR));
    q.push_back(mk(1, 3'd1, 0, 0, 1, FET));
    q.push_back(mk(1, 3'd1, 0, 0, 0, P));
    q.push_back(mk(1, 3'd1, 0, 0, 0, M_IRA | M_DBD | M_WR | M_PAS | M_ALU));
    q.push_back(mk(0, 3'd1, 0, 0, 0, P | M_CLR));
    q.push_back(mk(1, 3'd0, 0, 0, 0, P | M_CLR));
    q.push_back(mk(1, 3'd0, 0, 0, 0, P | M_RD));
    foreach (q[i]) begin
      @(negedge clk);
      apply(q[i]);
      #1;
      e = sb.pop_front();
      n_run++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reset row %0d got %h required %h", i, obs, e);
      end
    end
  endtask

  task automatic test_add_mul;
    row_t q[$];
    logic [24:0] e;
    q.push_back(mk(1, 3'd2, 0, 0, 1, FET));
    q.push_back(mk(1, 3'd2, 0, 0, 0, P));
    q.push_back(mk(1, 3'd2, 0, 0, 0, M_PCA | M_DBD | M_ALU | M_ADD | M_LAC));
    q.push_back(mk(1, 3'd3, 0, 0, 1, FET));
    q.push_back(mk(1, 3'd3, 0, 0, 0, P));
    q.push_back(mk(1, 3'd3, 0, 0, 0, M_PCA | M_DBD | M_ALU | M_MUL | M_LAC));
    foreach (q[i]) begin
      @(negedge clk);
      apply(q[i]);
      #1;
      e = sb.pop_front();
      n_run++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL add_mul row %0d got %h required %h", i, obs, e);
      end
    end
  endtask

  task automatic test_sta_lda;
    row_t q[$];
    logic [24:0] e;
    logic [24:0] st;
    st = M_IRA | M_DBD | M_WR | M_PAS | M_ALU;
    q.push_back(mk(1, 3'd1, 0, 0, 1, FET));
    q.push_back(mk(1, 3'd1, 0, 0, 0, P));
    q.push_back(mk(1, 3'd1, 0, 0, 0, st));
    q.push_back(mk(1, 3'd1, 0, 0, 0, st));
    q.push_back(mk(1, 3'd1, 0, 0, 0, st));
    q.push_back(mk(1, 3'd1, 0, 0, 1, st));
    q.push_back(mk(1, 3'd0, 0, 0, 0, P | M_RD));
    q.push_back(mk(1, 3'd0, 0, 0, 1, FET));
    q.push_back(mk(1, 3'd0, 0, 0, 1, P));
    q.push_back(mk(1, 3'd0, 0, 0, 0, M_IRA | M_DOD | M_RD));
    q.push_back(mk(1, 3'd0, 0, 0, 1, M_IRA | M_DOD | M_RD | M_LAC));
    q.push_back(mk(1, 3'd0, 0, 0, 0, P | M_RD));
    foreach (q[i]) begin
      @(negedge clk);
      apply(q[i]);
      #1;
      e = sb.pop_front();
      n_run++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL sta_lda row %0d got %h required %h", i, obs, e);
      end
    end
  endtask

  task automatic test_jump;
    row_t q[$];
    logic [24:0] e;
    q.push_back(mk(1, 3'd5, 0, 0, 1, FET));
    q.push_back(mk(1, 3'd5, 0, 0, 1, P));
    q.push_back(mk(1, 3'd5, 0, 0, 1, P));
    q.push_back(mk(1, 3'd5, 0, 1, 1, FET));
    q.push_back(mk(1, 3'd5, 0, 1, 0, P));
    q.push_back(mk(1, 3'd5, 0, 1, 0, P | M_LPC));
    q.push_back(mk(1, 3'd4, 0, 0, 1, FET));
    q.push_back(mk(1, 3'd4, 0, 0, 0, P));
    q.push_back(mk(1, 3'd4, 0, 0, 0, P | M_LPC));
    q.push_back(mk(1, 3'd6, 0, 0, 1, FET));
    q.push_back(mk(1, 3'd6, 0, 0, 0, P));
    q.push_back(mk(1, 3'd6, 0, 0, 0, P | M_LDI));
    foreach (q[i]) begin
      @(negedge clk);
      apply(q[i]);
      #1;
      e = sb.pop_front();
      n_run++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL jump row %0d got %h required %h", i, obs, e);
      end
    end
  endtask

  task automatic test_misc;
    row_t q[$];
    logic [24:0] e;
    logic [24:0] m [16];
    for (int s = 0; s < 16; s++) m[s] = P;
    m[0] = P | M_IAC;
    m[1] = P | M_CMP;
    m[2] = P | M_SR;
    m[3] = P | M_SL;
    m[4] = P | M_ZER;
    m[5] = P | M_STC;
    m[6] = P | M_CLC;
    for (int s = 0; s < 16; s++) begin
      q.push_back(mk(1, 3'd7, 4'(s), 0, 1, FET));
      q.push_back(mk(1, 3'd7, 4'(s), 0, 0, P));
      q.push_back(mk(1, 3'd7, 4'(s), 0, 0, m[s]));
    end
    q.push_back(mk(1, 3'd7, 4'hF, 0, 1, P | M_HALT));
    q.push_back(mk(1, 3'd1, 4'h0, 1, 1, P | M_HALT));
    q.push_back(mk(1, 3'd2, 4'h0, 0, 0, P | M_HALT));
    foreach (q[i]) begin
      @(negedge clk);
      apply(q[i]);
      #1;
      e = sb.pop_front();
      n_run++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL misc row %0d got %h required %h", i, obs, e);
      end
    end
  endtask

  task automatic test_timeout;
    row_t q[$];
    logic [24:0] e;
    q.push_back(mk(0, 3'd0, 0, 0, 0, P | M_CLR));
    q.push_back(mk(1, 3'd0, 0, 0, 0, P | M_CLR));
    for (int k = 0; k < 15; k++)
      q.push_back(mk(1, 3'd0, 0, 0, 0, P | M_RD));
    q.push_back(mk(1, 3'd0, 0, 0, 0, P | M_HALT | M_BERR));
    q.push_back(mk(1, 3'd0, 0, 0, 1, P | M_HALT | M_BERR));
    q.push_back(mk(1, 3'd2, 0, 0, 1, P | M_HALT | M_BERR));
    q.push_back(mk(0, 3'd0, 0, 0, 0, P | M_CLR));
    q.push_back(mk(1, 3'd0, 0, 0, 0, P | M_CLR));
    q.push_back(mk(1, 3'd0, 0, 0, 1, FET));
    foreach (q[i]) begin
      @(negedge clk);
      apply(q[i]);
      #1;
      e = sb.pop_front();
      n_run++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL timeout row %0d got %h required %h", i, obs, e);
      end
    end
  endtask

  initial begin
    test_reset;
    test_add_mul;
    test_sta_lda;
    test_jump;
    test_misc;
    test_timeout;
    @(negedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
